// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Combinational EX-stage operand forwarding select for one ALU source.
module pipe_fwd_sel
    import pipe_hazard_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_mem_rd,
    input  logic       i_wb_regwrite,
    input  logic [4:0] i_wb_rd,
    output logic [1:0] o_fwd
);

    // The younger EX/MEM result shadows MEM/WB; r0 is hard-wired zero.
    always_comb begin
        o_fwd = FWD_RF;
        if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_src))
            o_fwd = FWD_MEM;
        else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_src))
            o_fwd = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / multiply hazard controller with forwarding selects.
// Define PIPE_HAZ_PERF_CNT_EN to build the saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic [4:0]       i_ex_rs,
    input  logic [4:0]       i_ex_rt,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_mul,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_regwrite,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_wb_regwrite,
    input  logic [4:0]       i_wb_rd,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_write,
    output logic             o_idex_bubble,
    output logic             o_exmem_bubble,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_h1,
    output logic             o_h2,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t     state;
    logic [3:0] mul_cnt;
    logic       ld_use;
    logic       hold;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign ld_use = i_ex_memread && (i_ex_rd != 5'd0) &&
                    ((i_id_use_rs && (i_id_rs == i_ex_rd)) ||
                     (i_id_use_rt && (i_id_rt == i_ex_rd)));

    assign hold = ((state == ST_RUN) && i_ex_mul) ||
                  ((state == ST_MUL) && (mul_cnt != 4'd0));

    // Entry cycle counts as the first hold cycle, so preload MUL_LAT-2.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_RUN;
            mul_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (i_ex_mul) begin
                        state   <= ST_MUL;
                        mul_cnt <= 4'(MUL_LAT - 2);
                    end
                end
                ST_MUL: begin
                    if (mul_cnt != 4'd0)
                        mul_cnt <= mul_cnt - 4'd1;
                    else
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_idex_write   = 1'b1;
        o_idex_bubble  = 1'b0;
        o_exmem_bubble = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_flush   = 1'b0;
        o_h1           = 1'b0;
        o_h2           = 1'b0;
        if (!i_rst_n) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (hold) begin
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_idex_write   = 1'b0;
            o_exmem_bubble = 1'b1;
            o_h1           = 1'b1;
        end else if (i_ex_br_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_h2         = 1'b1;
        end else if (ld_use) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
            o_h1          = 1'b1;
        end
    end

    pipe_fwd_sel u_fwd_a (
        .i_src          (i_ex_rs),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_fwd          (fwd_a_raw)
    );

    pipe_fwd_sel u_fwd_b (
        .i_src          (i_ex_rt),
        .i_mem_regwrite (i_mem_regwrite),
        .i_mem_rd       (i_mem_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .i_wb_rd        (i_wb_rd),
        .o_fwd          (fwd_b_raw)
    );

    assign o_fwd_a = i_rst_n ? fwd_a_raw : FWD_RF;
    assign o_fwd_b = i_rst_n ? fwd_b_raw : FWD_RF;

`ifdef PIPE_HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (o_h1 && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (o_h2 && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MUL_LAT = 4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs, id_use_rt, ex_memread, ex_mul, ex_br_taken;
    logic             mem_regwrite, wb_regwrite;
    logic             pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
    logic             ifid_flush, idex_flush, h1, h2;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       ctl;

    int checks   = 0;
    int failures = 0;

    // ctl bit order: pc, ifid_w, idex_w, idex_bub, exmem_bub, ifid_fl, idex_fl, h1, h2
    localparam logic [8:0] CTL_NONE  = 9'b111_00_00_00;
    localparam logic [8:0] CTL_RST   = 9'b000_00_11_00;
    localparam logic [8:0] CTL_HOLD  = 9'b000_01_00_10;
    localparam logic [8:0] CTL_LDUSE = 9'b001_10_00_10;
    localparam logic [8:0] CTL_FLUSH = 9'b111_00_11_01;

    assign ctl = {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
                  ifid_flush, idex_flush, h1, h2};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_use_rs    (id_use_rs),
        .i_id_use_rt    (id_use_rt),
        .i_ex_rs        (ex_rs),
        .i_ex_rt        (ex_rt),
        .i_ex_rd        (ex_rd),
        .i_ex_memread   (ex_memread),
        .i_ex_mul       (ex_mul),
        .i_ex_br_taken  (ex_br_taken),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_rd       (mem_rd),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_rd        (wb_rd),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_idex_write   (idex_write),
        .o_idex_bubble  (idex_bubble),
        .o_exmem_bubble (exmem_bubble),
        .o_ifid_flush   (ifid_flush),
        .o_idex_flush   (idex_flush),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_h1           (h1),
        .o_h2           (h2),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        ex_memread = 1'b0; ex_mul = 1'b0; ex_br_taken = 1'b0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; wb_regwrite = 1'b0; wb_rd = 5'd0;
    endtask

    // Advance one edge; inputs change 1 time unit after the edge, checks follow at +2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ex_rs = 5'd3; mem_regwrite = 1'b1; mem_rd = 5'd3;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
        step();
        settle();
        checks++;
        if (ctl !== CTL_RST) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RST);
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b});
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL post_reset_ctl: got %b expected %b", ctl, CTL_NONE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_LDUSE) begin
            failures++;
            $display("FAIL ld_use_rs: got %b expected %b", ctl, CTL_LDUSE);
        end
        step();
        ex_memread = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL ld_use_release: got %b expected %b", ctl, CTL_NONE);
        end
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL ld_use_r0: got %b expected %b", ctl, CTL_NONE);
        end
        ex_rd = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_use_rt = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL ld_use_rt_unused: got %b expected %b", ctl, CTL_NONE);
        end
        id_use_rt = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_LDUSE) begin
            failures++;
            $display("FAIL ld_use_rt: got %b expected %b", ctl, CTL_LDUSE);
        end
        step();
        idle_inputs();
        settle();
    endtask

    task automatic test_mul();
        do_reset();
        ex_mul = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ex_br_taken = (c == 1);
            settle();
            checks++;
            if (ctl !== CTL_HOLD) begin
                failures++;
                $display("FAIL mul_hold_c%0d: got %b expected %b", c, ctl, CTL_HOLD);
            end
            step();
        end
        ex_br_taken = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL mul_release: got %b expected %b", ctl, CTL_NONE);
        end
        step();
        ex_mul = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL mul_after: got %b expected %b", ctl, CTL_NONE);
        end
`ifdef PIPE_HAZ_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL mul_stall_cnt: got %0d expected 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_seq [0:5];
        exp_seq[0] = CTL_HOLD; exp_seq[1] = CTL_HOLD; exp_seq[2] = CTL_HOLD;
        exp_seq[3] = CTL_NONE; exp_seq[4] = CTL_HOLD; exp_seq[5] = CTL_HOLD;
        do_reset();
        ex_mul = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle();
            checks++;
            if (ctl !== exp_seq[c]) begin
                failures++;
                $display("FAIL b2b_mul_c%0d: got %b expected %b", c, ctl, exp_seq[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        ex_br_taken = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_FLUSH) begin
            failures++;
            $display("FAIL br_vs_ld_use: got %b expected %b", ctl, CTL_FLUSH);
        end
        step();
        idle_inputs();
        settle();
`ifdef PIPE_HAZ_PERF_CNT_EN
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd0, 32'd1}) begin
            failures++;
            $display("FAIL br_cnt: got %0d/%0d expected 0/1", stall_cnt, flush_cnt);
        end
`endif
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL br_after: got %b expected %b", ctl, CTL_NONE);
        end
    endtask

    task automatic test_fwd();
        ex_rs = 5'd7; ex_rt = 5'd7;
        mem_regwrite = 1'b1; mem_rd = 5'd7; wb_regwrite = 1'b1; wb_rd = 5'd7;
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1010) begin
            failures++;
            $display("FAIL fwd_mem: got %b expected 1010", {fwd_a, fwd_b});
        end
        mem_regwrite = 1'b0;
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0101) begin
            failures++;
            $display("FAIL fwd_wb: got %b expected 0101", {fwd_a, fwd_b});
        end
        ex_rs = 5'd0; ex_rt = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_r0: got %b expected 0000", {fwd_a, fwd_b});
        end
        ex_rs = 5'd7; ex_rt = 5'd4; mem_rd = 5'd7; wb_rd = 5'd4;
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1001) begin
            failures++;
            $display("FAIL fwd_split: got %b expected 1001", {fwd_a, fwd_b});
        end
        ex_rs = 5'd12; ex_rt = 5'd13;
        settle();
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_nomatch: got %b expected 0000", {fwd_a, fwd_b});
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        ex_mul = 1'b1;
        step();
        rst_n = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_RST) begin
            failures++;
            $display("FAIL mid_mul_rst: got %b expected %b", ctl, CTL_RST);
        end
        step();
        ex_mul = 1'b0;
        settle();
        checks++;
        if (ctl !== CTL_RST) begin
            failures++;
            $display("FAIL mid_mul_rst_held: got %b expected %b", ctl, CTL_RST);
        end
        step();
        rst_n = 1'b1;
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL mid_mul_after: got %b expected %b", ctl, CTL_NONE);
        end
        step();
        settle();
        checks++;
        if (ctl !== CTL_NONE) begin
            failures++;
            $display("FAIL mid_mul_after2: got %b expected %b", ctl, CTL_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_branch();
        test_fwd();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
